// File: rtl/wb_regfile.sv
// wb_regfile: register file fed by the writeback stream, with two
// write-through bypassed decode read ports and a per-register
// pending-write scoreboard that flags operands still in flight.
module wb_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0] writedata,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic              flush,
    output logic              busy1,
    output logic              busy2,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
    logic              err_q;
    logic              err_d;
    logic              hit1;
    logic              hit2;

    // Register array: cleared by reset, written by each valid writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_reg] <= writedata;
        end
    end

    // Scoreboard next state: per-register reserve/retire with flush and error detection.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                // Flush wins; a concurrent issue is dropped and a writeback
                // is not checked against the (discarded) reservations.
                cnt_d[i] = '0;
            end else if (issue_en && (issue_reg == ADDR_W'(i)) &&
                         wr_en && (wr_reg == ADDR_W'(i))) begin
                // Reserve and retire the same register: net zero.
                cnt_d[i] = cnt_q[i];
            end else if (issue_en && (issue_reg == ADDR_W'(i))) begin
                if (cnt_q[i] == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (wr_en && (wr_reg == ADDR_W'(i))) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end
        end
    end

    // Scoreboard state: pending counts and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_q <= err_d;
        end
    end

    // Bypass is gated by reset so outputs read zero immediately while rst is low.
    always_comb begin
        hit1     = rst && wr_en && (wr_reg == rd_reg1);
        hit2     = rst && wr_en && (wr_reg == rd_reg2);
        rd_data1 = hit1 ? writedata : regs_q[rd_reg1];
        rd_data2 = hit2 ? writedata : regs_q[rd_reg2];
        // The last outstanding write being bypassed this cycle is not a hazard.
        busy1    = (cnt_q[rd_reg1] != '0) && !(hit1 && (cnt_q[rd_reg1] == CNT_ONE));
        busy2    = (cnt_q[rd_reg2] != '0) && !(hit2 && (cnt_q[rd_reg2] == CNT_ONE));
        sb_err   = err_q;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed-vector bench for wb_regfile. Inputs change on the
// falling edge; combinational outputs are checked 1 ns later and registered
// effects are checked in the following cycle.
module tb_wb_regfile;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int CNT_W    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] writedata;
    logic [ADDR_W-1:0] rd_reg1;
    logic [ADDR_W-1:0] rd_reg2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_reg;
    logic              flush;
    logic              busy1;
    logic              busy2;
    logic              sb_err;

    int n_cmp = 0;
    int n_err = 0;

    wb_regfile #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_reg   (wr_reg),
        .writedata(writedata),
        .rd_reg1  (rd_reg1),
        .rd_reg2  (rd_reg2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .issue_en (issue_en),
        .issue_reg(issue_reg),
        .flush    (flush),
        .busy1    (busy1),
        .busy2    (busy2),
        .sb_err   (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        issue_en  = 1'b0;
        flush     = 1'b0;
        wr_reg    = '0;
        issue_reg = '0;
        writedata = '0;
    endtask

    // Advance to the next falling edge (one full cycle after the last one).
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        rd_reg1 = '0;
        rd_reg2 = '0;
        idle();

        // Reset state: every register reads zero, nothing busy, no error.
        #2;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_reg1 = ADDR_W'(i);
            rd_reg2 = ADDR_W'(NUM_REGS - 1 - i);
            #1;
            chk($sformatf("rst_rd1_r%0d", i), rd_data1, 32'h0);
            chk($sformatf("rst_rd2_r%0d", i), rd_data2, 32'h0);
            chk($sformatf("rst_busy1_r%0d", i), busy1, 32'h0);
            chk($sformatf("rst_busy2_r%0d", i), busy2, 32'h0);
        end
        chk("rst_sb_err", sb_err, 32'h0);
        cyc();
        rst = 1'b1;

        // Reserve r3, then write 0xBEEF with same-cycle read-through.
        cyc();
        issue_en = 1'b1; issue_reg = 3'd3; rd_reg1 = 3'd3;
        cyc();
        idle();
        #1;
        chk("r3_busy_after_issue", busy1, 32'h1);
        wr_en = 1'b1; wr_reg = 3'd3; writedata = 16'hBEEF;
        #1;
        chk("r3_bypass_data", rd_data1, 32'hBEEF);
        chk("r3_bypass_busy", busy1, 32'h0);
        cyc();
        idle();
        #1;
        chk("r3_stored_data", rd_data1, 32'hBEEF);
        chk("r3_busy_cleared", busy1, 32'h0);
        chk("r3_no_err", sb_err, 32'h0);

        // Issue r5 at cycle 0; busy from cycle 1; writeback 0x1234 at cycle 3.
        issue_en = 1'b1; issue_reg = 3'd5; rd_reg1 = 3'd5;
        #1;
        chk("r5_busy_c0_same_cycle_issue", busy1, 32'h0);
        cyc();
        idle();
        #1;
        chk("r5_busy_c1", busy1, 32'h1);
        cyc();
        #1;
        chk("r5_busy_c2", busy1, 32'h1);
        cyc();
        wr_en = 1'b1; wr_reg = 3'd5; writedata = 16'h1234;
        #1;
        chk("r5_busy_c3", busy1, 32'h0);
        chk("r5_data_c3", rd_data1, 32'h1234);
        cyc();
        idle();
        #1;
        chk("r5_data_c4", rd_data1, 32'h1234);
        chk("r5_busy_c4", busy1, 32'h0);

        // Saturate r2 at count 3, overflow sets sb_err, three writebacks drain.
        rd_reg2 = 3'd2;
        for (int k = 0; k < 3; k++) begin
            issue_en = 1'b1; issue_reg = 3'd2;
            cyc();
        end
        idle();
        #1;
        chk("r2_busy_cnt3", busy2, 32'h1);
        chk("r2_err_before_overflow", sb_err, 32'h0);
        issue_en = 1'b1; issue_reg = 3'd2;
        cyc();
        idle();
        #1;
        chk("r2_err_after_overflow", sb_err, 32'h1);
        chk("r2_busy_after_overflow", busy2, 32'h1);
        wr_en = 1'b1; wr_reg = 3'd2; writedata = 16'h000A;
        #1;
        chk("r2_busy_wb1", busy2, 32'h1);
        cyc();
        wr_en = 1'b1; wr_reg = 3'd2; writedata = 16'h000B;
        #1;
        chk("r2_busy_wb2", busy2, 32'h1);
        cyc();
        wr_en = 1'b1; wr_reg = 3'd2; writedata = 16'h000C;
        #1;
        chk("r2_busy_wb3", busy2, 32'h0);
        cyc();
        idle();
        #1;
        chk("r2_busy_drained", busy2, 32'h0);
        chk("r2_data_final", rd_data2, 32'h000C);

        // Asynchronous reset clears sticky error and data without a clock edge.
        #1;
        rst = 1'b0;
        #1;
        chk("arst1_sb_err", sb_err, 32'h0);
        chk("arst1_rd2", rd_data2, 32'h0);
        cyc();
        rst = 1'b1;

        // Issue+writeback r4 together at count 1, then flush.
        issue_en = 1'b1; issue_reg = 3'd4; rd_reg1 = 3'd4; rd_reg2 = 3'd1;
        cyc();
        issue_en = 1'b1; issue_reg = 3'd4;
        wr_en = 1'b1; wr_reg = 3'd4; writedata = 16'h4444;
        #1;
        chk("r4_pair_bypass_data", rd_data1, 32'h4444);
        chk("r4_pair_busy_bypassed", busy1, 32'h0);
        cyc();
        idle();
        #1;
        chk("r4_pair_busy_after", busy1, 32'h1);
        chk("r4_pair_no_err", sb_err, 32'h0);
        flush = 1'b1; issue_en = 1'b1; issue_reg = 3'd4;
        wr_en = 1'b1; wr_reg = 3'd1; writedata = 16'h5555;
        cyc();
        idle();
        #1;
        chk("flush_busy1", busy1, 32'h0);
        chk("flush_wb_data", rd_data2, 32'h5555);
        chk("flush_no_err", sb_err, 32'h0);

        // Writeback r6 with no reservation: data lands, sb_err sets.
        wr_en = 1'b1; wr_reg = 3'd6; writedata = 16'h00FF; rd_reg1 = 3'd6;
        cyc();
        idle();
        #1;
        chk("r6_data", rd_data1, 32'h00FF);
        chk("r6_err", sb_err, 32'h1);

        // Reset mid-cycle with a writeback to r7 and a reservation in flight.
        issue_en = 1'b1; issue_reg = 3'd6;
        wr_en = 1'b1; wr_reg = 3'd7; writedata = 16'hAAAA; rd_reg2 = 3'd7;
        #1;
        chk("r7_bypass_pre_rst", rd_data2, 32'hAAAA);
        rst = 1'b0;
        #1;
        chk("arst2_rd1", rd_data1, 32'h0);
        chk("arst2_rd2", rd_data2, 32'h0);
        chk("arst2_err", sb_err, 32'h0);
        chk("arst2_busy1", busy1, 32'h0);
        chk("arst2_busy2", busy2, 32'h0);
        cyc();
        idle();
        rst = 1'b1;
        #1;
        chk("post_rst_r7", rd_data2, 32'h0);
        chk("post_rst_r6", rd_data1, 32'h0);
        chk("post_rst_busy1", busy1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Register file that consumes the writeback stream (destination register plus selected write data) and serves two decode-stage read ports. Reads are write-through bypassed, so a value written back in a cycle is visible the same cycle. A per-register pending-write scoreboard tells decode when a source operand is still in flight. It sits between the writeback select logic and the decode/hazard logic.

Parameters:
DATA_W, 16, register and data width
NUM_REGS, 8, number of architectural registers
ADDR_W, 3, register index width; must satisfy 2**ADDR_W == NUM_REGS
CNT_W, 2, pending-count width per register; at most 2**CNT_W-1 writes in flight

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-low reset
wr_en  in  1  writeback valid
wr_reg  in  ADDR_W  writeback destination register
writedata  in  DATA_W  writeback data, already selected
rd_reg1  in  ADDR_W  read port 1 index
rd_reg2  in  ADDR_W  read port 2 index
rd_data1  out  DATA_W  read port 1 data, combinational
rd_data2  out  DATA_W  read port 2 data, combinational
issue_en  in  1  decode issues an instruction that will write issue_reg
issue_reg  in  ADDR_W  destination register being reserved
flush  in  1  pipeline flush; clears all reservations
busy1  out  1  rd_reg1 value not yet available
busy2  out  1  rd_reg2 value not yet available
sb_err  out  1  sticky scoreboard error flag

Behaviour:
- Reset (rst low, asynchronous):
  - All registers = 0.
  - All pending counts = 0.
  - sb_err = 0.
  - rd_data reflects zeros; busy1 = busy2 = 0.
  - Reset mid-operation discards any in-progress writeback.
- Write: on a rising edge with wr_en = 1, regs[wr_reg] <= writedata. Every register is writable; there is no hard-wired zero register.
- Read: rd_dataN = writedata when wr_en = 1 and wr_reg == rd_regN; otherwise regs[rd_regN]. Zero cycles of latency.
- Scoreboard: one CNT_W-bit count per register, updated on each rising edge.
  - issue_en only, no matching writeback: count[issue_reg] + 1.
  - wr_en only: count[wr_reg] - 1.
  - Both set with issue_reg == wr_reg: count unchanged.
  - Both set with different registers: each updated independently.
  - Increment when count is at its maximum: increment dropped, sb_err <= 1.
  - wr_en when count[wr_reg] == 0: register is still written, count stays 0, sb_err <= 1.
- Flush: all counts <= 0 on the next edge.
  - An issue in the same cycle as flush is dropped.
  - A writeback in the same cycle as flush still updates the register and does not set sb_err.
- busyN = (count[rd_regN] != 0), except busyN = 0 when wr_en = 1, wr_reg == rd_regN and count[rd_regN] == 1. In that case the last pending value is being bypassed this cycle.
- busyN ignores the same-cycle issue_en; a reservation becomes visible the cycle after issue.
- sb_err clears only on reset.

Test Plan:
- Reset, then read r0..r7 -> rd_data = 0x0000, busy = 0, sb_err = 0.
- wr_en=1, wr_reg=3, writedata=0xBEEF with rd_reg1=3 in the same cycle -> rd_data1 = 0xBEEF that cycle. Next cycle with wr_en=0 -> rd_data1 = 0xBEEF.
- issue_en, issue_reg=5 at cycle 0 -> busy1 (rd_reg1=5) = 1 from cycle 1. Writeback to r5 = 0x1234 at cycle 3 -> busy1 = 0 and rd_data1 = 0x1234 in cycle 3.
- Issue r2 three times -> count 3; a fourth issue -> sb_err = 1, count stays 3. Three writebacks -> busy clears on the third.
- Issue r4 and writeback r4 in the same cycle, starting from count 1 -> count stays 1, busy stays 1. Flush -> busy = 0 next cycle, sb_err = 0.
- Writeback r6 = 0x00FF with count 0 -> register written, sb_err = 1. Assert rst low mid-sequence -> all outputs zero immediately, without waiting for a clock edge.
